uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver: a successor to the fixed 8-bit receiver with configurable data width, 1 or 2 stop bits and a built-in input synchroniser. Reception uses 3-sample majority-vote oversampling, and glitches on the start bit are rejected. Line-break detection is included. It sits in the UART clock domain and feeds a parallel word plus validity/error strobes to the downstream data-sync/FIFO stage.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- PRESCALE_WIDTH, 6, width of PRESCALE port
- CLK  in  1  oversampling clock
- RST  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line; idle high; asynchronous to CLK
- PRESCALE  in  PRESCALE_WIDTH  CLK cycles per bit; legal: even, 6..2^PRESCALE_WIDTH-2 (8/16/32 required)
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP_2  in  1  1 = two stop bits
- P_DATA  out  DATA_WIDTH  last good word (LSB received first)
- DATA_VALID  out  1  one-cycle pulse, good frame
- PAR_ERR  out  1  one-cycle pulse, parity mismatch
- STP_ERR  out  1  one-cycle pulse, stop bit 0 (non-break)
- BREAK_DET  out  1  one-cycle pulse, break detected
- BUSY  out  1  high while not in IDLE

## Operation
- RX_IN passes through a 2-flop synchroniser, reset value 1; all logic uses the synchronised value (rx_s).
- Config latch: PRESCALE, PAR_EN, PAR_TYP and STOP_2 are captured in the cycle start is detected. Changes mid-frame have no effect until the next frame.
- Counters:
  - edge_cnt runs 0..P-1 per bit and wraps to 0 at P-1.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples and is decided at edge_cnt = P/2+1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE: when rx_s = 0, go to START; that cycle has edge_cnt = 0.
  - START: if the decided bit is 1 (glitch), return to IDLE at the decision cycle with no output. Otherwise go to DATA at the end of the bit.
  - DATA: shift the decided bit into the shift register at bit position bit_cnt. After bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN, else STOP1.
  - PARITY: expected parity = ^data for even, ~^data for odd. Record any mismatch, then go to STOP1 at the end of the bit.
  - STOP1, with STOP_2 = 0: this is the final stop bit; evaluate at the decision cycle and go to IDLE.
  - STOP1, with STOP_2 = 1: a 0 is recorded as a stop error; go to STOP2 at the end of the bit. STOP2 is then the final stop bit, evaluated at its decision cycle, then IDLE.
- Final evaluation, in priority order:
  - Break: all data bits 0, parity bit 0 (if enabled) and stop bit 0. Pulse BREAK_DET, go to BRK_WAIT. STP_ERR and PAR_ERR are suppressed.
  - Else stop error: pulse STP_ERR. PAR_ERR also pulses if parity failed.
  - Else parity error: pulse PAR_ERR.
  - Else: load P_DATA and pulse DATA_VALID.
- BRK_WAIT: remain until rx_s = 1, then go to IDLE. No start is detected while in BRK_WAIT.
- P_DATA changes only on a good frame and holds otherwise.
- Reset (any time, including mid-frame):
  - State IDLE, counters 0, shift register 0.
  - P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR, BREAK_DET, BUSY = 0.
  - Synchroniser flops = 1.

## Timing
- Start detection: 2–3 CLK cycles after RX_IN falls, due to the synchroniser.
- Strobe latency: all strobes are registered and appear in the cycle after the final decision cycle.
  - N = 1 + DATA_WIDTH + PAR_EN + STOP_2 bits precede the final stop bit.
  - The strobe is high at cycle N·P + P/2 + 2 counted from the detection cycle (cycle 0), and lasts exactly 1 cycle.
- Back-to-back frames: the FSM is in IDLE from the cycle after the final decision. A start edge arriving at the nominal end of the stop bit is captured; no idle gap is required.
- BUSY: high from the detection cycle through the final decision cycle. It stays high throughout BRK_WAIT.
- At most one of DATA_VALID / STP_ERR / BREAK_DET is high in any cycle. PAR_ERR may coincide only with STP_ERR.

## Test plan
- P=8, DATA_WIDTH=8, even parity, 1 stop, data 0xA5 (parity bit 0) -> DATA_VALID single pulse at detection + 10·8 + 6, P_DATA = 0xA5, no errors.
- P=16 and P=32, odd parity, 2 stop bits, data 0x3C sent back-to-back twice with no idle gap -> two DATA_VALID pulses spaced 12·P cycles apart, P_DATA = 0x3C.
- P=16, odd parity, 0x3C with parity bit inverted -> PAR_ERR pulse, no DATA_VALID, P_DATA keeps previous value. Same frame with second stop bit 0 -> STP_ERR pulse.
- RX_IN low for 3 cycles at P=16 -> no strobe; BUSY falls at detection + 10. A following valid 0x55 frame with no parity is received correctly.
- RX_IN held low for 12 bit-times at P=8, parity enabled -> exactly one BREAK_DET, no STP_ERR/PAR_ERR, BUSY high until line high. Next frame 0x81 -> DATA_VALID, P_DATA = 0x81.
- DATA_WIDTH=5 build: RST asserted mid-DATA -> all outputs 0 immediately. After release, frame 0x1B -> P_DATA = 0x1B. PRESCALE changed mid-frame -> frame still decoded with the latched P.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line, frame configuration and received-word strobes of the UART receiver
// Signals:
//   rx_in      - serial line, idle high, asynchronous to the receiver clock
//   prescale   - clock cycles per bit (even, 6 .. 2^PRESCALE_WIDTH-2)
//   par_en     - 1 = a parity bit follows the data bits
//   par_typ    - 0 = even parity, 1 = odd parity
//   stop_2     - 1 = two stop bits
//   p_data     - last good word, LSB received first
//   data_valid - one-cycle pulse for a good frame
//   par_err    - one-cycle pulse for a parity mismatch
//   stp_err    - one-cycle pulse for a zero stop bit (non-break)
//   break_det  - one-cycle pulse for a line break
//   busy       - high while the receiver is not idle
// Modports: master drives the line and the config, slave is the receiver.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      rx_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      par_typ;
    logic                      stop_2;
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      par_err;
    logic                      stp_err;
    logic                      break_det;
    logic                      busy;
    modport master (
        output rx_in, prescale, par_en, par_typ, stop_2,
        input  p_data, data_valid, par_err, stp_err, break_det, busy
    );
    modport slave (
        input  rx_in, prescale, par_en, par_typ, stop_2,
        output p_data, data_valid, par_err, stp_err, break_det, busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with input synchroniser, 3-sample majority
//              voting, glitch-rejecting start detection and line-break detection
// Ports:
//   clk   - oversampling clock, prescale cycles per bit
//   rst_n - asynchronous active-low reset
//   bus   - uart_rx_cfg_if.slave: rx_in and frame config in, p_data and strobes out
module uart_rx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_cfg_if.slave bus
);
    localparam int                        BW       = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]             BIT_ONE  = BW'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT} state_t;

    state_t                    state, state_nx;
    logic                      sync1, rx_s;
    logic [PRESCALE_WIDTH-1:0] p_lat, half, edge_cnt, edge_nx;
    logic                      par_en_l, par_typ_l, stop_2_l;
    logic [BW-1:0]             bit_cnt, bit_nx;
    logic [DATA_WIDTH-1:0]     shreg, shreg_nx, p_data;
    logic                      s0, s1, bit_val, decide, bit_end, start_det, final_eval;
    logic                      par_bit, par_bit_nx, par_fail, par_fail_nx, stp1_err, stp1_err_nx;
    logic                      brk, stp, dv_nx, pe_nx, se_nx, bd_nx;
    logic                      data_valid, par_err, stp_err, break_det;

    assign half      = p_lat >> 1;
    assign decide    = edge_cnt == half + ONE;
    assign bit_end   = edge_cnt == p_lat - ONE;
    assign start_det = (state == IDLE) && !rx_s;
    // majority of the two earlier samples and the live synchronised line
    assign bit_val   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {sync1, rx_s} <= 2'b11;
        else {sync1, rx_s} <= {bus.rx_in, sync1};

    // frame configuration is frozen for the whole frame at start detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            p_lat     <= '0;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            stop_2_l  <= 1'b0;
        end else if (start_det) begin
            p_lat     <= bus.prescale;
            par_en_l  <= bus.par_en;
            par_typ_l <= bus.par_typ;
            stop_2_l  <= bus.stop_2;
        end

    always_comb begin
        state_nx    = state;
        bit_nx      = bit_cnt;
        shreg_nx    = shreg;
        par_bit_nx  = par_bit;
        par_fail_nx = par_fail;
        stp1_err_nx = stp1_err;
        final_eval  = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_nx    = START;
                bit_nx      = '0;
                par_bit_nx  = 1'b0;
                par_fail_nx = 1'b0;
                stp1_err_nx = 1'b0;
            end
            START: if (decide && bit_val) state_nx = IDLE;
                   else if (bit_end) state_nx = DATA;
            DATA: begin
                if (decide) shreg_nx[bit_cnt] = bit_val;
                if (bit_end) begin
                    bit_nx = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_ONE;
                    if (bit_cnt == LAST_BIT) state_nx = par_en_l ? PARITY : STOP1;
                end
            end
            PARITY: begin
                // expected parity bit is ^data for even and its inverse for odd
                if (decide) begin
                    par_bit_nx  = bit_val;
                    par_fail_nx = bit_val != ((^shreg) ^ par_typ_l);
                end
                if (bit_end) state_nx = STOP1;
            end
            STOP1: if (stop_2_l) begin
                if (decide && !bit_val) stp1_err_nx = 1'b1;
                if (bit_end) state_nx = STOP2;
            end else begin
                final_eval = decide;
            end
            STOP2: final_eval = decide;
            BRK_WAIT: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        brk   = final_eval && !bit_val && (shreg == '0) && !(par_en_l && par_bit);
        stp   = final_eval && !brk && (!bit_val || stp1_err);
        bd_nx = brk;
        se_nx = stp;
        pe_nx = final_eval && !brk && par_fail;
        dv_nx = final_eval && !brk && !stp && !par_fail;
        if (final_eval) state_nx = brk ? BRK_WAIT : IDLE;
        edge_nx = (state == IDLE || state_nx == IDLE || state_nx == BRK_WAIT || bit_end) ? '0 : edge_cnt + ONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            par_bit  <= 1'b0;
            par_fail <= 1'b0;
            stp1_err <= 1'b0;
        end else begin
            state    <= state_nx;
            edge_cnt <= edge_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
            s0       <= (edge_cnt == half - ONE) ? rx_s : s0;
            s1       <= (edge_cnt == half) ? rx_s : s1;
            par_bit  <= par_bit_nx;
            par_fail <= par_fail_nx;
            stp1_err <= stp1_err_nx;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            p_data     <= dv_nx ? shreg : p_data;
            data_valid <= dv_nx;
            par_err    <= pe_nx;
            stp_err    <= se_nx;
            break_det  <= bd_nx;
        end

    assign bus.p_data     = p_data;
    assign bus.data_valid = data_valid;
    assign bus.par_err    = par_err;
    assign bus.stp_err    = stp_err;
    assign bus.break_det  = break_det;
    assign bus.busy       = state != IDLE;
endmodule
